// File: rtl/sigmoid_pkg.sv
// Shared definitions for the fixed-point sigmoid evaluator.
// This package provides the sequencer states, the Q8.24 defaults, the
// segment centres, and the helpers that map |x| to a segment and to that
// segment's expansion centre.
package sigmoid_pkg;

    // Default data format, Q8.24.
    localparam int DWIDTH_D = 32;
    localparam int FRAC_D   = 24;
    localparam int NTERMS_D = 4;
    localparam int IWIDTH_D = DWIDTH_D - FRAC_D;

    // 1.0 in Q8.24.
    localparam logic [DWIDTH_D-1:0] ONE_Q = 32'h0100_0000;

    // Segment encoding. Segment 6 marks the saturated tail, where the
    // evaluation is skipped and 1.0 is used instead.
    typedef logic [2:0] seg_t;
    localparam seg_t SEG_POLY_MAX = 3'd4;
    localparam seg_t SEG_SAT      = 3'd6;

    // Expansion centres for segments 0..4, in Q8.24.
    localparam logic [DWIDTH_D-1:0] CENTRE_0 = 32'h0000_0000; // 0.0
    localparam logic [DWIDTH_D-1:0] CENTRE_1 = 32'h0180_0000; // 1.5
    localparam logic [DWIDTH_D-1:0] CENTRE_2 = 32'h0280_0000; // 2.5
    localparam logic [DWIDTH_D-1:0] CENTRE_3 = 32'h0380_0000; // 3.5
    localparam logic [DWIDTH_D-1:0] CENTRE_4 = 32'h0500_0000; // 5.0

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MAC   = 3'd2,
        ST_FINAL = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Map a non-negative magnitude to its segment using the integer field.
    // Integer parts 0..3 use their own segment. Integer parts 4 and 5 share
    // segment 4. Anything from 6.0 upward is saturated.
    function automatic seg_t seg_of(input logic [DWIDTH_D-1:0] a);
        logic [IWIDTH_D-1:0] ip;
        ip = a[DWIDTH_D-1:FRAC_D];
        if (ip < IWIDTH_D'(4))
            return seg_t'(ip);
        else if (ip < IWIDTH_D'(6))
            return SEG_POLY_MAX;
        else
            return SEG_SAT;
    endfunction

    // Expansion centre for a segment. The saturated segment never uses its
    // offset, so it maps to zero.
    function automatic logic [DWIDTH_D-1:0] centre_of(input seg_t seg);
        case (seg)
            3'd0:    return CENTRE_0;
            3'd1:    return CENTRE_1;
            3'd2:    return CENTRE_2;
            3'd3:    return CENTRE_3;
            3'd4:    return CENTRE_4;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/sigmoid_mac_step.sv
// One Horner step in Q-format: o_acc = ((i_acc * i_d) >>> FRAC) + i_coef.
// The block is purely combinational. The product is kept at full double
// width. The shift floors toward -inf, and the final add wraps without
// saturating.
// Build option: define SIGMOID_ROUND_EN to add half an LSB before the shift,
// which gives round-half-up instead of truncation.
module sigmoid_mac_step
    import sigmoid_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_D,
    parameter int FRAC   = FRAC_D
) (
    input  logic signed [DWIDTH-1:0] i_acc,
    input  logic signed [DWIDTH-1:0] i_d,
    input  logic signed [DWIDTH-1:0] i_coef,
    output logic signed [DWIDTH-1:0] o_acc
);

    localparam int PW = 2 * DWIDTH;

`ifdef SIGMOID_ROUND_EN
    localparam logic signed [PW-1:0] HALF_LSB = PW'(1) <<< (FRAC - 1);
`endif

    logic signed [PW-1:0] w_acc_ext;
    logic signed [PW-1:0] w_d_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_biased;

    // Multiply at full width, optionally bias, rescale, then add the coefficient.
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_acc_ext = {{DWIDTH{i_acc[DWIDTH-1]}}, i_acc};
        w_d_ext   = {{DWIDTH{i_d[DWIDTH-1]}}, i_d};
        w_prod    = w_acc_ext * w_d_ext;
`ifdef SIGMOID_ROUND_EN
        w_biased  = w_prod + HALF_LSB;
`else
        w_biased  = w_prod;
`endif
        o_acc     = DWIDTH'(w_biased >>> FRAC) + i_coef;
    end

endmodule

// File: rtl/sigmoid_horner_ctrl.sv
// Sequencer for the fixed-point sigmoid evaluator.
// It accepts a signed Q8.24 operand and classifies |x| into a segment. It
// walks the coefficient lookup from the highest term down and evaluates the
// series by Horner's rule on one shared multiply-add step. It folds negative
// operands with sigma(-x) = 1 - sigma(x) and holds the result on a
// valid/ready handshake.
// Build option: SIGMOID_ROUND_EN selects round-half-up in each multiply-add
// step. The default is truncation. Latency is the same in both builds.
module sigmoid_horner_ctrl
    import sigmoid_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_D,
    parameter int FRAC   = FRAC_D,
    parameter int NTERMS = NTERMS_D
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DWIDTH-1:0]         in_x,
    output logic [2:0]                coef_seg,
    output logic [$clog2(NTERMS)-1:0] coef_idx,
    input  logic [DWIDTH-1:0]         coef_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DWIDTH-1:0]         out_y,
    output logic                      busy
);

    localparam int IW = $clog2(NTERMS);

    localparam logic [DWIDTH-1:0] MAX_POS = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

    localparam logic [IW-1:0] IDX_TOP  = IW'(NTERMS - 1);
    localparam logic [IW-1:0] IDX_NEXT = IW'(NTERMS - 2);

    // Operand classification, used only at the IDLE handshake.
    logic              w_neg;
    logic [DWIDTH-1:0] w_abs;
    seg_t              w_seg;
    logic [DWIDTH-1:0] w_d;

    // Result of the shared multiply-add step.
    logic [DWIDTH-1:0] w_mac;

    // Sequencer state and the latched operand.
    state_t            r_state;
    logic              r_sign;
    seg_t              r_seg;
    logic [DWIDTH-1:0] r_d;
    logic [DWIDTH-1:0] r_acc;

    // Registered outputs. coef_idx also serves as the Horner term counter k.
    logic [2:0]        r_coef_seg;
    logic [IW-1:0]     r_coef_idx;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DWIDTH-1:0] r_out_y;
    logic              r_busy;

    // Compute the magnitude, segment and centre offset of the incoming operand.
    always_comb begin
        w_neg = in_x[DWIDTH-1];
        if (!w_neg)
            w_abs = in_x;
        else if (in_x == MIN_NEG)
            w_abs = MAX_POS;
        else
            w_abs = -in_x;
        w_seg = seg_of(w_abs);
        w_d   = w_abs - centre_of(w_seg);
    end

    sigmoid_mac_step #(
        .DWIDTH (DWIDTH),
        .FRAC   (FRAC)
    ) u_mac_step (
        .i_acc  (r_acc),
        .i_d    (r_d),
        .i_coef (coef_data),
        .o_acc  (w_mac)
    );

    // Sequencer FSM: IDLE -> LOAD -> MAC x (NTERMS-1) -> FINAL -> HOLD -> IDLE.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sign      <= 1'b0;
            r_seg       <= '0;
            r_d         <= '0;
            r_acc       <= '0;
            r_coef_seg  <= '0;
            r_coef_idx  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign     <= w_neg;
                        r_seg      <= w_seg;
                        r_d        <= w_d;
                        r_coef_seg <= w_seg;
                        r_coef_idx <= IDX_TOP;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (r_seg == SEG_SAT) begin
                        r_acc   <= ONE_Q;
                        r_state <= ST_FINAL;
                    end else begin
                        r_acc      <= coef_data;
                        r_coef_idx <= IDX_NEXT;
                        r_state    <= ST_MAC;
                    end
                end

                ST_MAC: begin
                    r_acc <= w_mac;
                    if (r_coef_idx == '0)
                        r_state <= ST_FINAL;
                    else
                        r_coef_idx <= r_coef_idx - IW'(1);
                end

                ST_FINAL: begin
                    r_out_y     <= r_sign ? (ONE_Q - r_acc) : r_acc;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end

                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign coef_seg  = r_coef_seg;
    assign coef_idx  = r_coef_idx;
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sigmoid_horner_ctrl.sv
// Self-checking bench for sigmoid_horner_ctrl.
// A behavioural coefficient table answers the lookup combinationally. A
// reference model computes y and the expected latency for each operand.
// Expectations are queued on drive and popped when the result appears.
// Latency is counted in clock edges, from the edge that samples in_valid up
// to and including the edge after which out_valid is seen high.
// Build option: SIGMOID_ROUND_EN is honoured by the reference model.
module tb_sigmoid_horner_ctrl;

    localparam logic [31:0] ONE = 32'h0100_0000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [2:0]  coef_seg;
    logic [1:0]  coef_idx;
    logic [31:0] coef_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] y;
        int          lat;
    } exp_t;

    exp_t sb[$];

    sigmoid_horner_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .coef_seg  (coef_seg),
        .coef_idx  (coef_idx),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural coefficient table in Q8.24. Unused segments return a poison value.
    function automatic logic [31:0] coef_model(input logic [2:0] seg, input logic [1:0] idx);
        logic [31:0] t [0:4][0:3];
        t[0] = '{32'h0080_0000, 32'h0040_0000, 32'h0000_0000, 32'hFFFA_AAAB};
        t[1] = '{32'h00D1_A7F9, 32'h002E_2B9A, 32'hFFF0_E1C2, 32'h0001_2345};
        t[2] = '{32'h00EC_1E8A, 32'h0012_E4F0, 32'hFFF9_1A2B, 32'h0003_4567};
        t[3] = '{32'h00F8_A1C3, 32'h0006_F3B1, 32'hFFFC_8D2E, 32'h0001_6789};
        t[4] = '{32'h00FE_E9E0, 32'h0001_A3C5, 32'hFFFF_5B7D, 32'h0000_789A};
        if (seg > 3'd4) return 32'hDEAD_BEEF;
        return t[seg][idx];
    endfunction

    always_comb coef_data = coef_model(coef_seg, coef_idx);

    // Reference model: result and latency for one operand.
    function automatic logic [31:0] model_y(input logic [31:0] x, output int lat);
        logic [31:0]        a;
        int                 ip;
        int                 seg;
        logic [31:0]        centre [0:4];
        logic signed [31:0] d;
        logic signed [31:0] acc;
        longint             p;
        centre = '{32'h0000_0000, 32'h0180_0000, 32'h0280_0000,
                   32'h0380_0000, 32'h0500_0000};
        if (x == 32'h8000_0000) a = 32'h7FFF_FFFF;
        else if (x[31])         a = 32'd0 - x;
        else                    a = x;
        ip  = int'(a[31:24]);
        seg = (ip < 4) ? ip : ((ip < 6) ? 4 : 6);
        if (seg == 6) begin
            acc = ONE;
            lat = 3;
        end else begin
            d   = a - centre[seg];
            acc = coef_model(3'(seg), 2'd3);
            for (int k = 2; k >= 0; k--) begin
                p = longint'(acc) * longint'(d);
`ifdef SIGMOID_ROUND_EN
                p = p + (64'sd1 <<< 23);
`endif
                acc = 32'(p >>> 24) + coef_model(3'(seg), 2'(k));
            end
            lat = 6;
        end
        return x[31] ? (ONE - acc) : acc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one operand, wait (bounded) for its result, and check it. Then
    // hold back-pressure for 'hold' cycles, while offering a competing
    // operand that must be ignored, and finally accept the result.
    task automatic run_op(input logic [31:0] x, input int hold);
        exp_t        e;
        int          lat;
        logic [31:0] y_seen;
        e.y = model_y(x, e.lat);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        sb.push_back(e);
        in_x     = x;
        in_valid = 1'b1;
        lat      = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_x     = $urandom();
            lat++;
        end while (!out_valid && lat < 40);
        check("out_valid_seen", {31'd0, out_valid}, 32'd1);
        e = sb.pop_front();
        check($sformatf("out_y x=%h", x), out_y, e.y);
        check($sformatf("latency x=%h", x), lat, e.lat);
        y_seen = out_y;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_x     = 32'h0200_0000;
            @(posedge clk); #1;
            check("hold_y_stable", out_y, y_seen);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_busy", {31'd0, busy}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] xr;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_y", out_y, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_coef_seg", {29'd0, coef_seg}, 32'd0);
        check("rst_coef_idx", {30'd0, coef_idx}, 32'd0);

        // Directed operands, including the segment boundaries and saturated paths.
        run_op(32'h0000_0000, 0);
        check("x0_value", out_y, 32'h0080_0000);
        run_op(32'h0700_0000, 0);
        check("pos7_value", out_y, 32'h0100_0000);
        run_op(32'hF900_0000, 0);
        check("neg7_value", out_y, 32'h0000_0000);
        run_op(32'h8000_0000, 0);
        check("minneg_value", out_y, 32'h0000_0000);
        run_op(32'hFE80_0000, 0);
        run_op(32'h0180_0000, 0);
        run_op(32'h03FF_FFFF, 0);
        run_op(32'h0400_0000, 0);
        run_op(32'h05FF_FFFF, 0);
        run_op(32'h0600_0000, 0);
        run_op(32'hFA00_0001, 0);
        run_op(32'h7FFF_FFFF, 0);
        run_op(32'hFF00_0000, 0);

        // Back-pressure: four cycles without out_ready, then the next operand.
        run_op(32'h0100_0000, 4);
        run_op(32'h0240_0000, 0);

        // Reset during the second MAC cycle discards the operation.
        in_x     = 32'h00C0_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mac_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out_y", out_y, 32'd0);
        run_op(32'h0000_0000, 0);
        check("after_abort_value", out_y, 32'h0080_0000);

        // Random operands: half full-range, half within +/-8.0.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 1) == 0)
                xr = $urandom();
            else
                xr = 32'($urandom_range(0, 32'h0FFF_FFFF)) - 32'h0800_0000;
            run_op(xr, (i % 97 == 0) ? 2 : 0);
        end

        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
